// File: rtl/hls_deadlock_monitor_param.sv
// Per-instance deadlock monitor: combines owned AXIS stall flags and child monitor
// blocks into a raw condition, filters it by persistence, and records source/events.
module hls_deadlock_monitor_param #(
  parameter int unsigned          NUM_AXIS  = 4,
  parameter int unsigned          NUM_IDLE  = 5,
  parameter int unsigned          NUM_SUB   = 1,
  parameter logic [NUM_AXIS-1:0]  AXIS_MASK = 4'b0100,
  parameter bit                   SUB_PAR   = 1'b0,
  parameter int unsigned          THRESH    = 1,
  parameter bit                   STICKY    = 1'b0,
  parameter bit                   IDLE_GATE = 1'b1,
  parameter int unsigned          EVT_W     = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_AXIS-1:0]         axis_block_sigs,
  input  logic [NUM_IDLE-1:0]         inst_idle_sigs,
  input  logic [NUM_SUB-1:0]          inst_block_sigs,
  input  logic                        clear,
  output logic                        block,
  output logic [NUM_SUB+NUM_AXIS-1:0] block_src,
  output logic [EVT_W-1:0]            evt_count
);

  typedef enum logic [1:0] {S_IDLE, S_SUSPECT, S_BLOCKED} state_t;

  state_t                      state_q, state_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic [NUM_SUB+NUM_AXIS-1:0] src_q, src_d;
  logic [EVT_W-1:0]            evt_q, evt_d;

  logic axis_hit, sub_hit, idle_all, raw, enter;

  always_comb begin
    axis_hit = |(axis_block_sigs & AXIS_MASK);
    sub_hit  = SUB_PAR ? (&inst_block_sigs) : (|inst_block_sigs);
    idle_all = IDLE_GATE && (&inst_idle_sigs);
    raw      = (axis_hit | sub_hit) & ~idle_all;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    evt_d   = evt_q;
    enter   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (raw) begin
          if (THRESH <= 1) begin
            state_d = S_BLOCKED;
            enter   = 1'b1;
          end else begin
            state_d = S_SUSPECT;
            cnt_d   = 8'd1;
          end
        end
      end
      S_SUSPECT: begin
        if (!raw) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q + 8'd1 == 8'(THRESH)) begin
          state_d = S_BLOCKED;
          cnt_d   = '0;
          enter   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      S_BLOCKED: begin
        if (!STICKY && !raw) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enter) begin
      src_d = {inst_block_sigs, axis_block_sigs & AXIS_MASK};
      if (evt_q != '1) evt_d = evt_q + EVT_W'(1);
    end else if (state_d != S_BLOCKED) begin
      src_d = '0;
    end

    // clear wins over everything evaluated above, including a same-cycle entry
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      src_d   = '0;
      evt_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      evt_q   <= evt_d;
    end
  end

  assign block     = (state_q == S_BLOCKED);
  assign block_src = src_q;
  assign evt_count = evt_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Drives five differently-configured monitors from shared stimulus and checks
// them against a run-length reference model through a scoreboard queue.
module tb_hls_deadlock_monitor_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] axis  = '0;
  logic [4:0] idle  = '0;
  logic       ib1   = 1'b0;
  logic [1:0] ib2   = '0;
  logic       clr   = 1'b0;

  logic       blk0, blk1, blk2, blk3, blk4;
  logic [4:0] src0, src1, src3, src4;
  logic [5:0] src2;
  logic [7:0] evt0, evt1, evt2, evt3;
  logic [1:0] evt4;

  always #5 clock = ~clock;

  hls_deadlock_monitor_param u0 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(ib1), .clear(clr), .block(blk0), .block_src(src0), .evt_count(evt0));

  hls_deadlock_monitor_param #(.THRESH(4)) u1 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(ib1), .clear(clr), .block(blk1), .block_src(src1), .evt_count(evt1));

  hls_deadlock_monitor_param #(.NUM_SUB(2), .SUB_PAR(1'b1)) u2 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(ib2), .clear(clr), .block(blk2), .block_src(src2), .evt_count(evt2));

  hls_deadlock_monitor_param #(.STICKY(1'b1)) u3 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(ib1), .clear(clr), .block(blk3), .block_src(src3), .evt_count(evt3));

  hls_deadlock_monitor_param #(.EVT_W(2)) u4 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(ib1), .clear(clr), .block(blk4), .block_src(src4), .evt_count(evt4));

  typedef struct packed {
    logic [4:0]      blk;
    logic [4:0][5:0] src;
    logic [4:0][7:0] evt;
  } exp_t;

  exp_t q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  int th[5]     = '{1, 4, 1, 1, 1};
  bit sticky[5] = '{0, 0, 0, 1, 0};
  int evmax[5]  = '{255, 255, 255, 255, 3};

  // Reference: block is "raw held for at least THRESH consecutive cycles since last clear".
  int         run[5];
  bit         mblk[5];
  logic [5:0] msrc[5];
  int         mevt[5];

  task automatic chk(input string tag, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s[u%0d] t=%0t observed=%0h expected=%0h", tag, idx, $time, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] ax, input logic i1, input logic [1:0] i2,
                      input logic [4:0] idl, input logic c, input logic r);
    exp_t       e;
    logic       sh, rw, nb, ent;
    logic [5:0] snap;
    logic [5:0] as[5];
    logic [7:0] ae[5];
    logic       ab[5];
    @(negedge clock);
    axis = ax; ib1 = i1; ib2 = i2; idle = idl; clr = c; reset = r;
    for (int i = 0; i < 5; i++) begin
      sh   = (i == 2) ? (i2 == 2'b11) : i1;
      rw   = (ax[2] | sh) & (idl != 5'b11111);
      snap = (i == 2) ? {i2, 1'b0, ax[2], 2'b00} : {1'b0, i1, 1'b0, ax[2], 2'b00};
      if (r || c) begin
        run[i] = 0; mblk[i] = 1'b0; msrc[i] = '0; mevt[i] = 0;
      end else begin
        run[i] = rw ? ((run[i] < 1000) ? run[i] + 1 : run[i]) : 0;
        nb  = (sticky[i] && mblk[i]) || (run[i] >= th[i]);
        ent = nb && !mblk[i];
        if (ent) msrc[i] = snap;
        else if (!nb) msrc[i] = '0;
        if (ent && mevt[i] < evmax[i]) mevt[i] = mevt[i] + 1;
        mblk[i] = nb;
      end
      e.blk[i] = mblk[i];
      e.src[i] = msrc[i];
      e.evt[i] = 8'(mevt[i]);
    end
    q.push_back(e);
    @(posedge clock);
    #1;
    e = q.pop_front();
    ab = '{blk0, blk1, blk2, blk3, blk4};
    as = '{{1'b0, src0}, {1'b0, src1}, src2, {1'b0, src3}, {1'b0, src4}};
    ae = '{evt0, evt1, evt2, evt3, {6'b0, evt4}};
    for (int i = 0; i < 5; i++) begin
      chk("block", i, {7'b0, ab[i]}, {7'b0, e.blk[i]});
      chk("block_src", i, {2'b0, as[i]}, {2'b0, e.src[i]});
      chk("evt_count", i, ae[i], e.evt[i]);
    end
  endtask

  task automatic ax_cycles(input logic [3:0] ax, input int n);
    for (int k = 0; k < n; k++) step(ax, 1'b0, 2'b00, 5'b00000, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      run[i] = 0; mblk[i] = 1'b0; msrc[i] = '0; mevt[i] = 0;
    end
    // reset state
    step(4'b0000, 1'b0, 2'b00, 5'b00000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 2'b00, 5'b00000, 1'b0, 1'b1);
    ax_cycles(4'b0000, 2);
    // single-cycle stall on the owned channel; unowned channels ignored
    ax_cycles(4'b0100, 1);
    ax_cycles(4'b0000, 3);
    ax_cycles(4'b1011, 2);
    // short pulse below THRESH=4, then a long one
    ax_cycles(4'b0100, 3);
    ax_cycles(4'b0000, 1);
    ax_cycles(4'b0100, 5);
    ax_cycles(4'b0000, 3);
    // parallel children: one blocked, then both
    step(4'b0000, 1'b0, 2'b01, 5'b00000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 2'b11, 5'b00000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 2'b00, 5'b00000, 1'b0, 1'b0);
    ax_cycles(4'b0000, 2);
    // idle gating
    step(4'b0100, 1'b0, 2'b00, 5'b11111, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 2'b00, 5'b11111, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 2'b00, 5'b11110, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 2'b00, 5'b11110, 1'b0, 1'b0);
    ax_cycles(4'b0000, 2);
    // sticky latch, then clear together with raw
    ax_cycles(4'b0100, 1);
    ax_cycles(4'b0000, 3);
    step(4'b0100, 1'b0, 2'b00, 5'b00000, 1'b1, 1'b0);
    ax_cycles(4'b0100, 1);
    ax_cycles(4'b0000, 2);
    step(4'b0000, 1'b0, 2'b00, 5'b00000, 1'b1, 1'b0);
    // five separate events for counter saturation
    for (int k = 0; k < 5; k++) begin
      ax_cycles(4'b0100, 1);
      ax_cycles(4'b0000, 1);
    end
    // sequential child monitor
    step(4'b0000, 1'b1, 2'b00, 5'b00000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 2'b00, 5'b00000, 1'b0, 1'b0);
    ax_cycles(4'b0000, 2);
    // reset while THRESH=4 instance is in SUSPECT
    ax_cycles(4'b0100, 2);
    step(4'b0100, 1'b0, 2'b00, 5'b00000, 1'b0, 1'b1);
    ax_cycles(4'b0000, 2);
    // mixed traffic
    for (int k = 0; k < 60; k++)
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1) & $urandom_range(0, 1)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 5'b11111 : 5'b00000,
           ($urandom_range(0, 15) == 0), 1'b0);
    n_cmp++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
